// File: rtl/calc_pkg.sv
// Shared encodings for the calculator op sequencer: op select fields and FSM states.
package calc_pkg;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam int         OP_MUL_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/calc_wait_timer.sv
// 4-bit loadable down-counter timing the datapath settling window.
// Expire is combinational from the count; load wins over decrement, and decrement stops at 0.
module calc_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] value,
    output logic       expire
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign value  = cnt_q;
    assign expire = (cnt_q == 4'd1);

endmodule

// File: rtl/calc_op_sequencer.sv
// Request/response sequencer for the 4-bit calculator: accept, hold operands W cycles, capture result.
// Accept-to-res_valid latency is W+1 cycles; requests stall until the held result is consumed.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int ADD_WAIT = 1,
    parameter int MUL_WAIT = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_x,
    input  logic [3:0]       req_y,
    input  logic [1:0]       req_op,
    input  logic             req_chain,
    output logic [3:0]       calc_x,
    output logic [3:0]       calc_y,
    output logic [1:0]       calc_op_sel,
    input  logic [7:0]       calc_result,
    input  logic             calc_carry,
    input  logic             calc_overflow,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic             res_carry,
    output logic             res_overflow,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [3:0] ADD_W4 = 4'(ADD_WAIT);
    localparam logic [3:0] MUL_W4 = 4'(MUL_WAIT);

    state_t           state_q;
    logic [3:0]       calc_x_q, calc_y_q;
    logic [1:0]       calc_op_q;
    logic             res_valid_q, res_carry_q, res_ovf_q, have_prev_q;
    logic [7:0]       res_data_q;
    logic [CNT_W-1:0] op_count_q;

    logic             accept;
    logic [3:0]       wait_load_d;
    logic [3:0]       wait_value;
    logic             wait_expire;

    assign accept      = (state_q == IDLE) && req_valid;
    assign wait_load_d = req_op[OP_MUL_BIT] ? MUL_W4 : ADD_W4;

    calc_wait_timer u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (wait_load_d),
        .dec      (state_q == EXEC),
        .value    (wait_value),
        .expire   (wait_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            calc_x_q    <= 4'd0;
            calc_y_q    <= 4'd0;
            calc_op_q   <= 2'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'd0;
            res_carry_q <= 1'b0;
            res_ovf_q   <= 1'b0;
            have_prev_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        // Chaining only makes sense once a result has been captured since reset.
                        calc_x_q  <= (req_chain && have_prev_q) ? res_data_q[3:0] : req_x;
                        calc_y_q  <= req_y;
                        calc_op_q <= req_op;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    if (wait_expire) begin
                        res_data_q  <= calc_result;
                        res_carry_q <= calc_op_q[OP_MUL_BIT] ? 1'b0 : calc_carry;
                        res_ovf_q   <= calc_op_q[OP_MUL_BIT] ? 1'b0 : calc_overflow;
                        res_valid_q <= 1'b1;
                        have_prev_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                        if (op_count_q != {CNT_W{1'b1}}) begin
                            op_count_q <= op_count_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign calc_x       = calc_x_q;
    assign calc_y       = calc_y_q;
    assign calc_op_sel  = calc_op_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_carry    = res_carry_q;
    assign res_overflow = res_ovf_q;
    assign op_count     = op_count_q;

    logic unused_ok;
    assign unused_ok = ^wait_value;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with a behavioural 4-bit calculator datapath.
module tb_calc_op_sequencer;
    import calc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_chain;
    logic [3:0] req_x, req_y;
    logic [1:0] req_op;
    logic [3:0] calc_x, calc_y;
    logic [1:0] calc_op_sel;
    logic [7:0] calc_result;
    logic       calc_carry, calc_overflow;
    logic       res_valid, res_ready, res_carry, res_overflow, busy;
    logic [7:0] res_data;
    logic [7:0] op_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    calc_op_sequencer #(.ADD_WAIT(1), .MUL_WAIT(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .req_op(req_op), .req_chain(req_chain),
        .calc_x(calc_x), .calc_y(calc_y), .calc_op_sel(calc_op_sel),
        .calc_result(calc_result), .calc_carry(calc_carry), .calc_overflow(calc_overflow),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_overflow(res_overflow),
        .busy(busy), .op_count(op_count)
    );

    // Datapath model; for multiply it deliberately drives carry/overflow high.
    logic [3:0] dp_y;
    logic [4:0] dp_sum;
    always_comb begin
        dp_y          = calc_op_sel[0] ? ~calc_y : calc_y;
        dp_sum        = {1'b0, calc_x} + {1'b0, dp_y} + {4'd0, calc_op_sel[0]};
        calc_result   = {4'd0, dp_sum[3:0]};
        calc_carry    = dp_sum[4];
        calc_overflow = (calc_x[3] == dp_y[3]) && (dp_sum[3] != calc_x[3]);
        if (calc_op_sel[OP_MUL_BIT]) begin
            calc_result   = {4'd0, calc_x} * {4'd0, calc_y};
            calc_carry    = 1'b1;
            calc_overflow = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_data"},  32'(res_data), 32'd0);
        check({tag, "_res_flags"}, 32'({res_carry, res_overflow}), 32'd0);
        check({tag, "_calc"},      32'({calc_x, calc_y, calc_op_sel}), 32'd0);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_op_count"},  32'(op_count), 32'd0);
    endtask

    task automatic do_op(input logic [3:0] x, input logic [3:0] y, input logic [1:0] op,
                         input logic chain, input logic [3:0] exp_cx, input logic [7:0] exp_d,
                         input logic exp_c, input logic exp_v, input int exp_lat);
        int lat;
        check("pre_req_ready", 32'(req_ready), 32'd1);
        req_x = x; req_y = y; req_op = op; req_chain = chain; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 40) begin
            check("exec_calc", 32'({calc_x, calc_y, calc_op_sel}), 32'({exp_cx, y, op}));
            check("exec_busy", 32'({busy, req_ready}), 32'b10);
            tick();
            lat++;
        end
        check("latency",   32'(lat), 32'(exp_lat));
        check("res_data",  32'(res_data), 32'(exp_d));
        check("res_flags", 32'({res_carry, res_overflow}), 32'({exp_c, exp_v}));
        check("done_rdy",  32'(req_ready), 32'd0);
        tick();
        if (exp_cnt < 255) exp_cnt++;
        check("post_valid", 32'(res_valid), 32'd0);
        check("post_busy",  32'(busy), 32'd0);
        check("op_count",   32'(op_count), 32'(exp_cnt));
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_x = 4'd0; req_y = 4'd0; req_op = 2'd0;
        req_chain = 1'b0; res_ready = 1'b1;
        tick(); tick();
        check_reset_state("reset");
        rst = 1'b0;

        // Chain right after reset must use req_x; doubles as the basic add.
        do_op(4'd3, 4'd4, OP_ADD, 1'b1, 4'd3, 8'h07, 1'b0, 1'b0, 2);
        do_op(4'd2, 4'd5, OP_SUB, 1'b0, 4'd2, 8'h0D, 1'b0, 1'b0, 2);
        do_op(4'd7, 4'd1, OP_ADD, 1'b0, 4'd7, 8'h08, 1'b0, 1'b1, 2);
        do_op(4'd15, 4'd15, 2'b10, 1'b0, 4'd15, 8'hE1, 1'b0, 1'b0, 3);
        do_op(4'd3, 4'd5, 2'b10, 1'b0, 4'd3, 8'h0F, 1'b0, 1'b0, 3);
        do_op(4'd0, 4'd1, OP_ADD, 1'b1, 4'hF, 8'h00, 1'b1, 1'b0, 2);
        do_op(4'd2, 4'd3, 2'b11, 1'b0, 4'd2, 8'h06, 1'b0, 1'b0, 3);

        // Backpressure: result held, new requests ignored.
        res_ready = 1'b0;
        req_x = 4'd1; req_y = 4'd1; req_op = OP_ADD; req_chain = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("bp_valid", 32'(res_valid), 32'd1);
        req_x = 4'd9; req_y = 4'd9; req_op = 2'b10; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(res_valid), 32'd1);
            check("bp_hold_data",  32'(res_data), 32'h02);
            check("bp_hold_rdy",   32'(req_ready), 32'd0);
            check("bp_hold_calc",  32'({calc_x, calc_y, calc_op_sel}), 32'({4'd1, 4'd1, 2'b00}));
            check("bp_hold_cnt",   32'(op_count), 32'd7);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        exp_cnt++;
        check("bp_release_valid", 32'(res_valid), 32'd0);
        check("bp_release_idle",  32'({busy, req_ready}), 32'b01);
        check("bp_release_cnt",   32'(op_count), 32'd8);

        // Reset during a multiply's execute window.
        req_x = 4'd9; req_y = 4'd9; req_op = 2'b10; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("abort");
        exp_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_valid", 32'(res_valid), 32'd0);
        end
        do_op(4'd5, 4'd1, OP_ADD, 1'b1, 4'd5, 8'h06, 1'b0, 1'b0, 2);

        for (int i = 0; i < 260; i++) begin
            do_op(4'd1, 4'd1, OP_ADD, 1'b0, 4'd1, 8'h02, 1'b0, 1'b0, 2);
        end
        check("sat_count", 32'(op_count), 32'd255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Request/response controller for the 4-bit calculator datapath: add, subtract (4-bit result), multiply (8-bit result).
- Accepts one operation at a time over a valid/ready request port and registers the operands.
- Drives the datapath for a programmable settling time per operation class, captures the result and flags, and holds them on a valid/ready response port.
- Supports chaining: the previous result's low nibble can be used as the next x operand.

Parameters:
- ADD_WAIT, 1, execute cycles for add/sub (legal 1..15).
- MUL_WAIT, 2, execute cycles for multiply (legal 1..15).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_x  in  4  operand x.
- req_y  in  4  operand y.
- req_op  in  2  00 add, 01 sub, 1x multiply (bit1 = mul select, bit0 = subtract).
- req_chain  in  1  use previous result[3:0] as x.
- calc_x  out  4  operand x to datapath.
- calc_y  out  4  operand y to datapath.
- calc_op_sel  out  2  op select to datapath.
- calc_result  in  8  datapath result (add/sub zero-extended).
- calc_carry  in  1  datapath carry out.
- calc_overflow  in  1  datapath signed overflow.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  8  captured result.
- res_carry  out  1  captured carry (0 for mul).
- res_overflow  out  1  captured overflow (0 for mul).
- busy  out  1  not IDLE.
- op_count  out  CNT_W  completed-result handshakes, saturating.

Behaviour:
- Reset: clk and rst (synchronous, active-high) are the only clock/reset. On rst=1 at a clk edge:
  - state=IDLE.
  - req_ready=1 (combinational from IDLE).
  - res_valid=0, res_data=0, res_carry=0, res_overflow=0.
  - calc_x=0, calc_y=0, calc_op_sel=0.
  - busy=0, op_count=0, have_prev=0, wait counter=0.
- rst mid-operation aborts immediately; no result is produced.
- States:
  - IDLE -> EXEC on req_valid&&req_ready.
  - EXEC -> DONE when the wait counter reaches 1.
  - DONE -> IDLE on res_valid&&res_ready.
- req_ready = (state==IDLE). There is no accept in DONE, no bypass and no queueing.
- Accept edge (cycle 0):
  - Register calc_y=req_y and calc_op_sel=req_op.
  - calc_x = (req_chain && have_prev) ? res_data[3:0] : req_x.
  - Load wait counter with MUL_WAIT if req_op[1], else ADD_WAIT.
- EXEC:
  - calc_* are held stable; the counter decrements each cycle.
  - The last EXEC cycle is cycle W; at its end, capture calc_result into res_data.
  - Capture carry/overflow, forced to 0 when op_sel[1]=1.
  - Set have_prev=1; state=DONE.
  - res_valid goes high at cycle W+1. Total accept-to-res_valid latency = W+1 cycles.
- DONE:
  - res_valid and all res_* held stable until res_ready is sampled high.
  - On the handshake: res_valid falls the next cycle, op_count increments (saturating at 2^CNT_W-1), state=IDLE.
  - res_data retains its value for chaining.
- req_op=1x with bit0=1 is treated as multiply.
- req_* inputs are ignored outside IDLE.
- busy = (state!=IDLE).

Decomposition:
- Package calc_pkg holds:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL_BIT=1.
  - state localparams IDLE/EXEC/DONE (2-bit).
- One natural sub-module: calc_wait_timer, a 4-bit loadable down-counter with load, value and expire ports.
- The datapath itself is instantiated outside this block at the top level.

Test Plan:
- Add: ADD_WAIT=1, x=3, y=4, op=00, res_ready=1 -> res_valid at cycle 2 after accept; res_data=8'h07, carry=0, ovf=0; op_count=1.
- Subtract and signed overflow:
  - x=2, y=5, op=01 -> res_data=8'h0D, carry=0, ovf=0.
  - x=7, y=1, op=00 -> res_data=8'h08, ovf=1.
- Multiply: MUL_WAIT=2, x=15, y=15, op=10 -> res_valid at cycle 3 after accept; res_data=8'hE1, carry=0, ovf=0; calc_* stable cycles 1-2.
- Chain: 3*5 -> 8'h0F; then chain=1, req_x=0, y=1, op=00 -> calc_x=4'hF, res_data=8'h00, carry=1. Chain request immediately after rst -> uses req_x.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_valid/res_data stable, req_ready=0, req_valid ignored, op_count unchanged; release -> IDLE next cycle.
- Reset mid-EXEC of a multiply -> next cycle all outputs at reset values, no res_valid, have_prev=0; op_count saturates at 255 after 260 ops (CNT_W=8).
